// File: rtl/snoopy_pkg.sv
// Shared definitions for the Snoopy game controller: state encoding,
// playfield limits and the obstacle position table.
package snoopy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PLAY = 3'd1,
    ST_HIT  = 3'd2,
    ST_WIN  = 3'd3,
    ST_OVER = 3'd4
  } game_state_t;

  localparam int         MAX_X_DEFAULT = 160;
  localparam int         NUM_OBSTACLES = 6;
  localparam logic [3:0] WIN_SCORE     = 4'd6;
  localparam logic [1:0] START_LIVES   = 2'd3;

  // Obstacle x positions, index 0 is the leftmost one. Scoring requires
  // clearing them in index order.
  localparam logic [NUM_OBSTACLES-1:0][7:0] OBSTACLE_X = {
    8'd154, 8'd127, 8'd114, 8'd81, 8'd61, 8'd55
  };

endpackage

// File: rtl/snoopy_obstacle_lut.sv
// Combinational lookup: is the given x position an obstacle, and which one.
module snoopy_obstacle_lut
  import snoopy_pkg::*;
(
  input  logic [7:0] x,
  output logic       is_obstacle,
  output logic [2:0] index
);

  // Positions in the table are unique, so at most one entry can match.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    is_obstacle = 1'b0;
    index       = '0;
    for (int i = 0; i < NUM_OBSTACLES; i++) begin
      if (x == OBSTACLE_X[i]) begin
        is_obstacle = 1'b1;
        index       = 3'(i);
      end
    end
  end

endmodule

// File: rtl/snoopy_game_ctrl.sv
// Game-level controller for the Snoopy side-scroller: paces horizontal steps,
// detects obstacle entry for scoring/collision, and sequences the game states.
module snoopy_game_ctrl
  import snoopy_pkg::*;
#(
  parameter int STEP_DIV   = 2,
  parameter int HIT_FRAMES = 30,
  parameter int MAX_X      = MAX_X_DEFAULT
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       airborne,
  input  logic [7:0] snoopy_x,
  output logic       step_left,
  output logic       step_right,
  output logic       clear_pos,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic [2:0] game_state
);

  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
  localparam logic [HIT_W-1:0] HIT_LAST = HIT_W'(HIT_FRAMES - 1);
  localparam logic [7:0]       X_RIGHT  = 8'(MAX_X);

  game_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [HIT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [7:0]       prev_x_q;
  logic [3:0]       score_d;
  logic [1:0]       lives_d;
  logic             step_left_d, step_right_d, clear_pos_d;

  logic             is_obstacle;
  logic [2:0]       obs_index;
  logic             entry;
  logic             step_due;

  snoopy_obstacle_lut u_lut (
    .x           (snoopy_x),
    .is_obstacle (is_obstacle),
    .index       (obs_index)
  );

  // An entry is arriving on an obstacle; standing still on one never counts.
  assign entry      = is_obstacle && (snoopy_x != prev_x_q);
  assign step_due   = frame_tick && (div_q == DIV_LAST);
  assign game_state = state_q;

  // Next-state and next-output logic; all results are registered below.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    hit_cnt_d    = hit_cnt_q;
    score_d      = score;
    lives_d      = lives;
    step_left_d  = 1'b0;
    step_right_d = 1'b0;
    clear_pos_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (start) begin
          state_d     = ST_PLAY;
          score_d     = '0;
          lives_d     = START_LIVES;
          div_d       = '0;
          hit_cnt_d   = '0;
          clear_pos_d = 1'b1;
        end
      end

      ST_PLAY: begin
        if (frame_tick) begin
          div_d = step_due ? '0 : div_q + DIV_W'(1);
        end
        // Collision outranks both winning and scoring; a step due on the
        // same frame is dropped because the game freezes.
        if (entry && !airborne) begin
          lives_d   = (lives != 2'd0) ? lives - 2'd1 : 2'd0;
          div_d     = '0;
          hit_cnt_d = '0;
          state_d   = ST_HIT;
        end else if (score == WIN_SCORE && snoopy_x == X_RIGHT) begin
          state_d = ST_WIN;
        end else begin
          if (entry && (prev_x_q < snoopy_x) && ({1'b0, obs_index} == score)
              && (score < WIN_SCORE)) begin
            score_d = score + 4'd1;
          end
          if (step_due && (key_left != key_right)) begin
            step_left_d  = key_left  && (snoopy_x != 8'd0);
            step_right_d = key_right && (snoopy_x != X_RIGHT);
          end
        end
      end

      ST_HIT: begin
        if (frame_tick) begin
          if (hit_cnt_q == HIT_LAST) begin
            hit_cnt_d = '0;
            state_d   = (lives == 2'd0) ? ST_OVER : ST_PLAY;
          end else begin
            hit_cnt_d = hit_cnt_q + HIT_W'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values, independent of statement order.
    if (!resetn) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      hit_cnt_q  <= '0;
      prev_x_q   <= '0;
      score      <= '0;
      lives      <= START_LIVES;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      clear_pos  <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      hit_cnt_q  <= hit_cnt_d;
      prev_x_q   <= snoopy_x;
      score      <= score_d;
      lives      <= lives_d;
      step_left  <= step_left_d;
      step_right <= step_right_d;
      clear_pos  <= clear_pos_d;
    end
  end

endmodule

// File: tb/tb_snoopy_game_ctrl.sv
// Self-checking bench for snoopy_game_ctrl: directed vector table, hand-written
// multi-cycle sequences, then randomized stimulus against a behavioural model.
module tb_snoopy_game_ctrl;
  import snoopy_pkg::*;

  localparam int STEP_DIV   = 2;
  localparam int HIT_FRAMES = 30;
  localparam int MAX_X      = 160;

  logic       clock = 1'b0;
  logic       resetn, frame_tick, start, key_left, key_right, airborne;
  logic [7:0] snoopy_x;
  logic       step_left, step_right, clear_pos;
  logic [3:0] score;
  logic [1:0] lives;
  logic [2:0] game_state;

  int n_checks = 0;
  int n_fail   = 0;

  int obst [6] = '{55, 61, 81, 114, 127, 154};

  // Behavioural model state.
  logic [2:0] m_state = ST_IDLE;
  int m_score = 0, m_lives = 3, m_frames = 0, m_hit = 0, m_prev = 0;
  bit m_sl = 0, m_sr = 0, m_clr = 0;

  typedef struct {
    bit rst, st, ft, kl, kr, air;
    logic [7:0] x;
    logic [2:0] e_state;
    int e_score, e_lives;
    bit e_sl, e_sr, e_clr;
  } vec_t;
  vec_t vecs [19];

  snoopy_game_ctrl #(.STEP_DIV(STEP_DIV), .HIT_FRAMES(HIT_FRAMES), .MAX_X(MAX_X)) dut (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .start(start),
    .key_left(key_left), .key_right(key_right), .airborne(airborne),
    .snoopy_x(snoopy_x), .step_left(step_left), .step_right(step_right),
    .clear_pos(clear_pos), .score(score), .lives(lives), .game_state(game_state)
  );

  always #5 clock = ~clock;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int obstacle_at(input int x);
    for (int i = 0; i < 6; i++) if (obst[i] == x) return i;
    return -1;
  endfunction

  // One clock of the game rules, applied to the inputs currently driven.
  task automatic model_clock();
    int idx = obstacle_at(int'(snoopy_x));
    bit arrived = (idx >= 0) && (int'(snoopy_x) != m_prev);
    bit step_frame = 0;
    m_sl = 0; m_sr = 0; m_clr = 0;
    if (!resetn) begin
      m_state = ST_IDLE; m_score = 0; m_lives = 3; m_frames = 0; m_hit = 0;
    end else if (m_state == ST_PLAY) begin
      if (frame_tick) begin
        m_frames++;
        step_frame = (m_frames % STEP_DIV) == 0;
      end
      if (arrived && !airborne) begin
        m_lives = m_lives - 1; m_frames = 0; m_hit = 0; m_state = ST_HIT;
      end else if (m_score == 6 && int'(snoopy_x) == MAX_X) begin
        m_state = ST_WIN;
      end else begin
        if (arrived && m_prev < int'(snoopy_x) && idx == m_score) m_score++;
        if (step_frame && key_left != key_right) begin
          m_sl = key_left && snoopy_x > 0;
          m_sr = key_right && int'(snoopy_x) < MAX_X;
        end
      end
    end else if (m_state == ST_HIT) begin
      if (frame_tick) begin
        m_hit++;
        if (m_hit == HIT_FRAMES) begin
          m_hit = 0;
          m_state = (m_lives == 0) ? ST_OVER : ST_PLAY;
        end
      end
    end else if (start) begin
      m_state = ST_PLAY; m_score = 0; m_lives = 3; m_frames = 0; m_clr = 1;
    end
    m_prev = int'(snoopy_x);
  endtask

  task automatic apply(input bit rst, st, ft, kl, kr, air, input logic [7:0] x);
    @(negedge clock);
    resetn = rst; start = st; frame_tick = ft;
    key_left = kl; key_right = kr; airborne = air; snoopy_x = x;
    @(posedge clock);
    model_clock();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_state"}, game_state, m_state);
    check({tag, "_score"}, score, m_score);
    check({tag, "_lives"}, lives, m_lives);
    check({tag, "_step_left"}, step_left, m_sl);
    check({tag, "_step_right"}, step_right, m_sr);
    check({tag, "_clear_pos"}, clear_pos, m_clr);
  endtask

  // Walk onto obstacle 61 from the left while grounded.
  task automatic collide();
    apply(1, 0, 0, 0, 0, 0, 8'd60);
    apply(1, 0, 0, 0, 0, 0, 8'd61);
  endtask

  // n frame_ticks in HIT with a key held; no strobes may appear.
  task automatic hit_wait(input int n);
    for (int k = 0; k < n; k++) begin
      apply(1, 0, 1, 0, 1, 0, 8'd61);
      check_model("hit");
      apply(1, 0, 0, 0, 0, 0, 8'd61);
    end
  endtask

  initial begin
    int pulses;
    int walk [12] = '{54, 55, 60, 61, 80, 81, 113, 114, 126, 127, 153, 154};

    resetn = 0; start = 0; frame_tick = 0; key_left = 0; key_right = 0;
    airborne = 0; snoopy_x = 0;

    //          rst st ft kl kr air x      state    sc lv sl sr clr
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 8'd0,  ST_IDLE, 0, 3, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 0, 8'd0,  ST_IDLE, 0, 3, 0, 0, 0};
    vecs[2]  = '{1, 1, 0, 0, 0, 0, 8'd0,  ST_PLAY, 0, 3, 0, 0, 1};
    vecs[3]  = '{1, 0, 1, 0, 1, 0, 8'd0,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[4]  = '{1, 0, 0, 0, 1, 0, 8'd0,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[5]  = '{1, 0, 1, 0, 1, 0, 8'd0,  ST_PLAY, 0, 3, 0, 1, 0};
    vecs[6]  = '{1, 0, 0, 0, 1, 0, 8'd1,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[7]  = '{1, 0, 1, 1, 1, 0, 8'd1,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[8]  = '{1, 0, 1, 1, 1, 0, 8'd1,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[9]  = '{1, 0, 1, 1, 0, 0, 8'd1,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[10] = '{1, 0, 1, 1, 0, 0, 8'd1,  ST_PLAY, 0, 3, 1, 0, 0};
    vecs[11] = '{1, 0, 1, 1, 0, 0, 8'd0,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[12] = '{1, 0, 1, 1, 0, 0, 8'd0,  ST_PLAY, 0, 3, 0, 0, 0};
    vecs[13] = '{1, 0, 0, 0, 0, 1, 8'd54, ST_PLAY, 0, 3, 0, 0, 0};
    vecs[14] = '{1, 0, 0, 0, 0, 1, 8'd55, ST_PLAY, 1, 3, 0, 0, 0};
    vecs[15] = '{1, 0, 0, 0, 0, 1, 8'd55, ST_PLAY, 1, 3, 0, 0, 0};
    vecs[16] = '{1, 0, 0, 0, 0, 1, 8'd54, ST_PLAY, 1, 3, 0, 0, 0};
    vecs[17] = '{1, 0, 0, 0, 0, 1, 8'd55, ST_PLAY, 1, 3, 0, 0, 0};
    vecs[18] = '{1, 1, 0, 0, 0, 1, 8'd55, ST_PLAY, 1, 3, 0, 0, 0};

    for (int i = 0; i < 19; i++) begin
      apply(vecs[i].rst, vecs[i].st, vecs[i].ft, vecs[i].kl, vecs[i].kr,
            vecs[i].air, vecs[i].x);
      check($sformatf("vec%0d_state", i), game_state, vecs[i].e_state);
      check($sformatf("vec%0d_score", i), score, vecs[i].e_score);
      check($sformatf("vec%0d_lives", i), lives, vecs[i].e_lives);
      check($sformatf("vec%0d_step_left", i), step_left, vecs[i].e_sl);
      check($sformatf("vec%0d_step_right", i), step_right, vecs[i].e_sr);
      check($sformatf("vec%0d_clear_pos", i), clear_pos, vecs[i].e_clr);
    end

    // Eight frame ticks with right held: a strobe after every second tick.
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      apply(1, 0, 1, 0, 1, 0, 8'd10);
      check($sformatf("right_tick%0d", k), step_right, (k % 2) == 1);
      pulses += int'(step_right);
      apply(1, 0, 0, 0, 1, 0, 8'd10);
      check("right_gap", step_right, 0);
      pulses += int'(step_right);
    end
    check("right_pulse_count", pulses, 4);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      apply(1, 0, 1, 1, 1, 0, 8'd10);
      pulses += int'(step_right) + int'(step_left);
    end
    check("both_keys_pulse_count", pulses, 0);

    // Three collisions drain the lives; the last one ends in OVER.
    for (int c = 0; c < 3; c++) begin
      collide();
      check($sformatf("hit%0d_state", c), game_state, ST_HIT);
      check($sformatf("hit%0d_lives", c), lives, 2 - c);
      hit_wait(HIT_FRAMES - 1);
      check($sformatf("hit%0d_still_frozen", c), game_state, ST_HIT);
      hit_wait(1);
      check($sformatf("hit%0d_exit", c), game_state, (c == 2) ? ST_OVER : ST_PLAY);
    end
    check("over_lives", lives, 0);
    apply(1, 1, 0, 0, 0, 0, 8'd61);
    check("restart_state", game_state, ST_PLAY);
    check("restart_lives", lives, 3);
    check("restart_score", score, 0);
    check("restart_clear", clear_pos, 1);
    apply(1, 0, 0, 0, 0, 0, 8'd61);
    check("restart_clear_once", clear_pos, 0);

    // Edge blocking at both ends of the track.
    apply(1, 0, 1, 0, 1, 0, 8'd160);
    apply(1, 0, 1, 0, 1, 0, 8'd160);
    check("right_edge_blocked", step_right, 0);
    apply(1, 0, 1, 1, 0, 0, 8'd0);
    apply(1, 0, 1, 1, 0, 0, 8'd0);
    check("left_edge_blocked", step_left, 0);

    // Clear all six obstacles airborne, then reach the right edge: WIN,
    // even though a step is due on that same frame.
    for (int k = 0; k < 12; k++) apply(1, 0, walk[k] == 153, 0, 0, 1, 8'(walk[k]));
    check("six_cleared", score, 6);
    apply(1, 0, 1, 0, 1, 1, 8'd160);
    check("win_state", game_state, ST_WIN);
    check("win_no_strobe", step_right, 0);
    for (int k = 0; k < 2; k++) begin
      apply(1, 0, 1, 0, 1, 1, 8'd160);
      check("win_hold", game_state, ST_WIN);
      check("win_hold_strobe", step_right, 0);
    end

    // Reset in the middle of a HIT freeze.
    apply(1, 1, 0, 0, 0, 0, 8'd160);
    check("replay_state", game_state, ST_PLAY);
    collide();
    check("hit_before_reset", game_state, ST_HIT);
    hit_wait(15);
    apply(0, 0, 0, 0, 1, 0, 8'd61);
    check("rst_state", game_state, ST_IDLE);
    check("rst_score", score, 0);
    check("rst_lives", lives, 3);
    check("rst_step_left", step_left, 0);
    check("rst_step_right", step_right, 0);
    check("rst_clear", clear_pos, 0);
    apply(1, 0, 0, 0, 0, 0, 8'd61);
    check_model("post_rst");

    // Randomized play against the model.
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom_range(0, 99);
      int cur = int'(snoopy_x);
      int nx;
      if (r < 40)      nx = cur;
      else if (r < 65) nx = (cur < MAX_X) ? cur + 1 : cur;
      else if (r < 80) nx = (cur > 0) ? cur - 1 : cur;
      else if (r < 92) nx = obst[$urandom_range(0, 5)] - 1;
      else             nx = ($urandom_range(0, 1) == 1) ? 0 : MAX_X;
      apply($urandom_range(0, 299) != 0, $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 8'(nx));
      check_model("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
